// File: rtl/mips16_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips16_multicycle_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS16 core
// Revision : 1.0 - initial release
// ============================================================================
module mips16_multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic [3:0]       opcode,
  input  logic             zero_in,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic             rf_we,
  output logic             wb_sel_mem,
  output logic             pc_en,
  output logic             pc_sel_br,
  output logic             illegal_op,
  output logic             bus_err,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  localparam int c_tmr_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYC - 1);

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_sru  = 4'h8;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_addi = 4'h9;
  localparam logic [3:0] c_op_ld   = 4'hA;
  localparam logic [3:0] c_op_st   = 4'hB;
  localparam logic [3:0] c_op_bz   = 4'hC;

  typedef enum logic [2:0] {
    st_fetch  = 3'd0,
    st_decode = 3'd1,
    st_exec   = 3'd2,
    st_mem    = 3'd3,
    st_wb     = 3'd4
  } state_t;

  state_t             r_state;
  logic [3:0]         r_op;
  logic [c_tmr_w-1:0] r_timer;
  logic [CNT_W-1:0]   r_retired;

  logic w_dec_nop;
  logic w_dec_illegal;
  logic w_imm_op;
  logic w_timeout;

  assign w_dec_illegal = (opcode >= 4'hD);
  assign w_dec_nop     = (opcode == c_op_nop) || w_dec_illegal;
  assign w_imm_op      = (r_op == c_op_addi) || (r_op == c_op_ld) || (r_op == c_op_st);
  assign w_timeout     = (r_timer == c_tmr_last);
  assign retired       = r_retired;

  // Outputs follow the registered state but react to same-cycle acks; all are
  // forced low while rst is asserted so an in-flight request drops at once.
  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    alu_op      = c_op_nop;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    wb_sel_mem  = 1'b0;
    pc_en       = 1'b0;
    pc_sel_br   = 1'b0;
    illegal_op  = 1'b0;
    bus_err     = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      busy = (r_state != st_fetch);
      case (r_state)
        st_fetch: begin
          imem_req = run;
          ir_load  = run & imem_ack;
          bus_err  = run & ~imem_ack & w_timeout;
        end
        st_decode: begin
          pc_en      = w_dec_nop;
          illegal_op = w_dec_illegal;
        end
        st_exec: begin
          alu_src_imm = w_imm_op;
          if (r_op <= c_op_sru) begin
            alu_op = r_op;
          end else if (r_op == c_op_bz) begin
            pc_en     = 1'b1;
            pc_sel_br = zero_in;
          end else begin
            alu_op = c_op_add;
          end
        end
        st_mem: begin
          dmem_req    = 1'b1;
          dmem_we     = (r_op == c_op_st);
          alu_src_imm = 1'b1;
          pc_en       = dmem_ack & (r_op == c_op_st);
          bus_err     = ~dmem_ack & w_timeout;
        end
        st_wb: begin
          rf_we       = 1'b1;
          wb_sel_mem  = (r_op == c_op_ld);
          alu_src_imm = w_imm_op;
          pc_en       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= st_fetch;
      r_op      <= c_op_nop;
      r_timer   <= '0;
      r_retired <= '0;
    end else begin
      if (pc_en) r_retired <= r_retired + CNT_W'(1);
      case (r_state)
        st_fetch: begin
          if (!run) begin
            r_timer <= '0;
          end else if (imem_ack) begin
            r_timer <= '0;
            r_state <= st_decode;
          end else if (w_timeout) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        st_decode: begin
          r_op    <= opcode;
          r_state <= w_dec_nop ? st_fetch : st_exec;
        end
        st_exec: begin
          r_timer <= '0;
          if (r_op == c_op_bz)                           r_state <= st_fetch;
          else if (r_op == c_op_ld || r_op == c_op_st)   r_state <= st_mem;
          else                                           r_state <= st_wb;
        end
        st_mem: begin
          if (dmem_ack) begin
            r_timer <= '0;
            r_state <= (r_op == c_op_ld) ? st_wb : st_fetch;
          end else if (w_timeout) begin
            // Abandon the access; PC is untouched so the same instruction refetches.
            r_timer <= '0;
            r_state <= st_fetch;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end
        st_wb:   r_state <= st_fetch;
        default: r_state <= st_fetch;
      endcase
    end
  end

endmodule
`default_nettype wire
